// File: rtl/spi_slv_ctl.sv
// SPI mode-0 slave: oversamples ss_n/sck/mosi in mclk, deserialises MOSI, serialises the tx frame MSB first.
// Latency: rx_vld/rx_err pulse SYNC_STAGES+2 mclk after the ss_n rising pin edge; MISO moves SYNC_STAGES+1 mclk after sck fall.
// Backpressure: none; tx_din is taken only if tx_vld at frame start, otherwise an all-zero frame goes out (tx_urun).
// Build option: SPI_SLV_ECHO_EN returns the last good rx_data instead of tx_din.
module spi_slv_ctl #(
   parameter int DATA_BITS   = 26,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 mclk,
   input  logic                 reset,
   input  logic                 ss_n,
   input  logic                 sck,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   input  logic [DATA_BITS-1:0] tx_din,
   input  logic                 tx_vld,
   output logic                 tx_ack,
   output logic                 tx_urun,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_vld,
   output logic                 rx_err,
   output logic                 busy
);

   localparam int CW = $clog2(DATA_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
   logic                   ss_hist_q, sck_hist_q;
   logic                   ss_s, sck_s, mosi_s;
   logic                   ss_fall, ss_rise, sck_rise, sck_fall;

   state_t                 state_q, state_d;
   logic                   start, in_shift, in_done;

   logic [DATA_BITS-1:0]   shift_tx_q, shift_rx_q, rx_data_q;
   logic [CW-1:0]          bit_cnt_q;
   logic                   miso_q, miso_oe_q, tx_ack_q, tx_urun_q, rx_vld_q, rx_err_q;

   logic [DATA_BITS-1:0]   tx_src;
   logic                   tx_take;

   // Synchronise the async pins; chains reset to the idle bus levels so release never looks like an edge
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         ss_sync_q   <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         ss_hist_q   <= 1'b1;
         sck_hist_q  <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         ss_hist_q   <= ss_s;
         sck_hist_q  <= sck_s;
      end
   end

   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign ss_fall  = ss_hist_q & ~ss_s;
   assign ss_rise  = ~ss_hist_q & ss_s;
   assign sck_rise = ~sck_hist_q & sck_s;
   assign sck_fall = sck_hist_q & ~sck_s;

`ifdef SPI_SLV_ECHO_EN
   // Loopback: the previous good frame is always available, so every start counts as an ack
   logic unused_tx;
   assign unused_tx = &{1'b0, tx_din, tx_vld};
   assign tx_src    = rx_data_q;
   assign tx_take   = 1'b1;
`else
   assign tx_src    = tx_vld ? tx_din : '0;
   assign tx_take   = tx_vld;
`endif

   // FSM state register
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; ss_fall inside SHIFT is not expected and is ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ss_fall) state_d = SHIFT;
         SHIFT:   if (ss_rise) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM decoded controls for the datapath
   always_comb begin
      start    = (state_q == IDLE) && ss_fall;
      in_shift = (state_q == SHIFT);
      in_done  = (state_q == DONE);
      busy     = (state_q != IDLE);
   end

   // Datapath: load at start, shift on sck edges, judge the frame in DONE
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         shift_tx_q <= '0;
         shift_rx_q <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         tx_ack_q   <= 1'b0;
         tx_urun_q  <= 1'b0;
         rx_vld_q   <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         tx_ack_q  <= 1'b0;
         tx_urun_q <= 1'b0;
         rx_vld_q  <= 1'b0;
         rx_err_q  <= 1'b0;
         if (start) begin
            shift_tx_q <= tx_src;
            shift_rx_q <= '0;
            miso_q     <= tx_src[DATA_BITS-1];
            miso_oe_q  <= 1'b1;
            bit_cnt_q  <= '0;
            tx_ack_q   <= tx_take;
            tx_urun_q  <= ~tx_take;
         end
         // a rise landing together with ss_rise is still counted before DONE judges the frame
         if (in_shift && sck_rise) begin
            shift_rx_q <= {shift_rx_q[DATA_BITS-2:0], mosi_s};
            if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 1'b1;
         end
         // zeros fill from the bottom, so MISO drops to 0 after the last bit
         if (in_shift && sck_fall) begin
            shift_tx_q <= {shift_tx_q[DATA_BITS-2:0], 1'b0};
            miso_q     <= shift_tx_q[DATA_BITS-2];
         end
         if (in_done) begin
            if (bit_cnt_q == CNT_FULL) begin
               rx_data_q <= shift_rx_q;
               rx_vld_q  <= 1'b1;
            end else begin
               rx_err_q  <= 1'b1;
            end
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
         end
      end
   end

   assign miso    = miso_q;
   assign miso_oe = miso_oe_q;
   assign tx_ack  = tx_ack_q;
   assign tx_urun = tx_urun_q;
   assign rx_data = rx_data_q;
   assign rx_vld  = rx_vld_q;
   assign rx_err  = rx_err_q;

endmodule

// File: tb/tb_spi_slv_ctl.sv
// Bench for spi_slv_ctl: time-driven SPI master, table of frames, scoreboard queues for rx and tx pulses.
// Runs the table with sck half-periods of 10 and 8 mclk, then corner sequences (coincident edges, reset mid-frame, echo).
// A monitor pops expected pulses as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_slv_ctl;
   localparam int DB = 26;
   localparam int SS = 2;

   logic          mclk = 1'b0;
   logic          reset, ss_n, sck, mosi, miso, miso_oe;
   logic [DB-1:0] tx_din, rx_data;
   logic          tx_vld, tx_ack, tx_urun, rx_vld, rx_err, busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DB-1:0] mosi_w;
      logic [DB-1:0] txd;
      logic          txv;
      int            nbits;
      logic          exp_ok;
      logic [DB-1:0] exp_miso;
   } vec_t;

   typedef struct {
      logic          ok;
      logic [DB-1:0] data;
   } rx_exp_t;

   vec_t          vecs[5];
   rx_exp_t       rx_q[$];
   logic          tx_q[$];
   logic [DB-1:0] last_good = '0;

   spi_slv_ctl #(.DATA_BITS(DB), .SYNC_STAGES(SS)) dut (
      .mclk(mclk), .reset(reset), .ss_n(ss_n), .sck(sck), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .tx_din(tx_din), .tx_vld(tx_vld),
      .tx_ack(tx_ack), .tx_urun(tx_urun), .rx_data(rx_data), .rx_vld(rx_vld),
      .rx_err(rx_err), .busy(busy)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every pulse must match the oldest pending expectation
   always @(posedge mclk) begin
      #1;
      if (rx_vld || rx_err) begin
         if (rx_q.size() == 0) chk("rx_unexpected", {30'd0, rx_vld, rx_err}, 32'd0);
         else begin
            rx_exp_t e;
            e = rx_q.pop_front();
            chk("rx_kind", {30'd0, rx_vld, rx_err}, {30'd0, e.ok, ~e.ok});
            chk("rx_data", 32'(rx_data), 32'(e.data));
         end
      end
      if (tx_ack || tx_urun) begin
         if (tx_q.size() == 0) chk("tx_unexpected", {30'd0, tx_ack, tx_urun}, 32'd0);
         else begin
            logic t;
            t = tx_q.pop_front();
            chk("tx_kind", {30'd0, tx_ack, tx_urun}, {30'd0, t, ~t});
         end
      end
   end

   task automatic wait_done_latency();
      int n = 0;
      do begin
         @(posedge mclk); #1; n++;
      end while (!(rx_vld || rx_err) && n < 20);
      chk("latency", 32'(n), 32'(SS + 2));
   endtask

   // One master transaction; simul makes the last sck rise coincide with ss_n rise
   task automatic run_frame(input logic [DB-1:0] mv, input logic [DB-1:0] tv, input logic tvld,
                            input int nbits, input int half, input bit simul,
                            input bit chk_miso, input logic [DB-1:0] exp_miso);
      logic [DB-1:0] rd;
      rx_exp_t       e;
      tx_din = tv;
      tx_vld = tvld;
`ifdef SPI_SLV_ECHO_EN
      tx_q.push_back(1'b1);
`else
      tx_q.push_back(tvld);
`endif
      e.ok   = (nbits == DB);
      e.data = e.ok ? mv : last_good;
      rx_q.push_back(e);
      if (e.ok) last_good = mv;
      rd = '0;
      @(posedge mclk); #($urandom_range(1, 9));
      ss_n = 1'b0;
      mosi = mv[DB-1];
      #(half * 10);
      chk("oe_selected", {31'd0, miso_oe}, 32'd1);
      chk("busy_selected", {31'd0, busy}, 32'd1);
      for (int i = 0; i < nbits; i++) begin
         sck = 1'b1;
         if (simul && i == nbits - 1) begin
            ss_n = 1'b1;
            break;
         end
         #(half * 10);
         rd   = {rd[DB-2:0], miso};
         sck  = 1'b0;
         if (i + 1 < DB) mosi = mv[DB-2-i];
         else            mosi = 1'b0;
         #(half * 10);
      end
      if (!simul) ss_n = 1'b1;
      wait_done_latency();
      sck = 1'b0;
      if (chk_miso) chk("miso_word", 32'(rd), 32'(exp_miso));
      tx_vld = 1'b0;
      #(half * 30);
   endtask

   initial begin
      logic [DB-1:0] exp;
      vecs[0] = '{26'h2A5_5A5A, 26'h155_AAAA, 1'b1, 26, 1'b1, 26'h155_AAAA};
      vecs[1] = '{26'h0F0_F0F0, 26'h333_3333, 1'b1, 13, 1'b0, 26'h000_0000};
      vecs[2] = '{26'h0AB_CDEF, 26'h155_AAAA, 1'b0, 26, 1'b1, 26'h000_0000};
      vecs[3] = '{26'h155_5555, 26'h2AA_AAAA, 1'b1, 27, 1'b0, 26'h000_0000};
      vecs[4] = '{26'h3C3_C3C3, 26'h000_0001, 1'b1, 26, 1'b1, 26'h000_0001};

      reset = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_din = '0; tx_vld = 1'b0;
      repeat (3) @(posedge mclk);
      #1;
      chk("rst_miso", {31'd0, miso}, 32'd0);
      chk("rst_oe", {31'd0, miso_oe}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pulses", {28'd0, tx_ack, tx_urun, rx_vld, rx_err}, 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      @(negedge mclk);
      reset = 1'b0;
      repeat (5) @(posedge mclk);

      foreach (vecs[k]) ;
      for (int d = 0; d < 2; d++) begin
         int half;
         half = (d == 0) ? 10 : 8;
         for (int i = 0; i < 5; i++) begin
            exp = vecs[i].exp_miso;
`ifdef SPI_SLV_ECHO_EN
            exp = last_good;
`endif
            run_frame(vecs[i].mosi_w, vecs[i].txd, vecs[i].txv, vecs[i].nbits, half,
                      1'b0, vecs[i].nbits == DB, exp);
         end
      end

      // last sck rise and ss_n rise together: the bit still counts, frame accepted
      run_frame(26'h2DE_ADBE, 26'h0, 1'b1, DB, 8, 1'b1, 1'b0, 26'h0);

      // reset mid-frame after 10 bits: immediate abort, no rx pulse
      tx_din = 26'h155_AAAA; tx_vld = 1'b1;
      tx_q.push_back(1'b1);
      @(posedge mclk); #($urandom_range(1, 9));
      ss_n = 1'b0; mosi = 1'b1;
      #80;
      for (int i = 0; i < 10; i++) begin
         sck = 1'b1; #80; sck = 1'b0; #80;
      end
      #23 reset = 1'b1;
      #1;
      chk("abort_miso", {31'd0, miso}, 32'd0);
      chk("abort_oe", {31'd0, miso_oe}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rx_data", 32'(rx_data), 32'd0);
      last_good = '0;
      ss_n = 1'b1; tx_vld = 1'b0;
      repeat (6) @(posedge mclk);
      chk("abort_miso_held", {31'd0, miso}, 32'd0);
      @(negedge mclk);
      reset = 1'b0;
      repeat (10) @(posedge mclk);
      exp = 26'h155_AAAA;
`ifdef SPI_SLV_ECHO_EN
      exp = '0;
`endif
      run_frame(26'h3FF_FFFF, 26'h155_AAAA, 1'b1, DB, 10, 1'b0, 1'b1, exp);
      chk("post_reset_rx", 32'(rx_data), 32'h3FF_FFFF);

`ifdef SPI_SLV_ECHO_EN
      run_frame(26'h123_4567, 26'h0, 1'b0, DB, 10, 1'b0, 1'b1, 26'h3FF_FFFF);
      run_frame(26'h0C0_FFEE, 26'h0, 1'b0, DB, 8, 1'b0, 1'b1, 26'h123_4567);
`endif

      repeat (20) @(posedge mclk);
      chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
      chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
